// File: rtl/lcd_write_arbiter_if.sv
// Client request ports and LCD pin bundle for lcd_write_arbiter.
// The slave side is the arbiter; the master side is the clients plus LCD.
interface lcd_write_arbiter_if;
   logic       req0_valid;
   logic       req0_row;
   logic [3:0] req0_col;
   logic [7:0] req0_char;
   logic       req0_ready;
   logic       req1_valid;
   logic       req1_row;
   logic [3:0] req1_col;
   logic [7:0] req1_char;
   logic       req1_ready;
   logic       init_done;
   logic       busy;
   logic       LCD_E;
   logic       LCD_RS;
   logic       LCD_RW;
   logic [7:0] LCD_DATA;

   modport slave (
      input  req0_valid, req0_row, req0_col, req0_char,
      input  req1_valid, req1_row, req1_col, req1_char,
      output req0_ready, req1_ready,
      output init_done, busy,
      output LCD_E, LCD_RS, LCD_RW, LCD_DATA
   );

   modport master (
      output req0_valid, req0_row, req0_col, req0_char,
      output req1_valid, req1_row, req1_col, req1_char,
      input  req0_ready, req1_ready,
      input  init_done, busy,
      input  LCD_E, LCD_RS, LCD_RW, LCD_DATA
   );
endinterface

// File: rtl/lcd_write_arbiter.sv
// 16x2 LCD power-up sequencer plus round-robin arbiter for two
// single-character write clients.
module lcd_write_arbiter #(
   parameter int PWR_WAIT = 70,
   parameter int E_PW     = 2,
   parameter int CMD_WAIT = 40,
   parameter int CLR_WAIT = 200
) (
   input  logic               clk,
   input  logic               rst,
   lcd_write_arbiter_if.slave bus
);
   localparam int M1 = (PWR_WAIT > CLR_WAIT) ? PWR_WAIT : CLR_WAIT;
   localparam int M2 = (M1 > CMD_WAIT) ? M1 : CMD_WAIT;
   localparam int M3 = (M2 > E_PW) ? M2 : E_PW;
   localparam int CW = (M3 > 1) ? $clog2(M3 + 1) : 1;

   localparam logic [CW-1:0] PWR_LAST = CW'(PWR_WAIT - 1);
   localparam logic [CW-1:0] EPW_LAST = CW'(E_PW - 1);
   localparam logic [CW-1:0] CMD_LAST = CW'(CMD_WAIT - 1);
   localparam logic [CW-1:0] CLR_LAST = CW'(CLR_WAIT - 1);

   typedef enum logic [2:0] {
      PWR_DLY, FS, EM, DON, CLR, IDLE, ADDR, CHAR
   } state_t;

   typedef enum logic [1:0] {
      SETUP, STROBE, HOLD
   } phase_t;

   typedef struct packed {
      logic       row;
      logic [3:0] col;
      logic [7:0] chr;
   } req_t;

   state_t        state;
   state_t        nxt_state;
   phase_t        phase;
   logic [CW-1:0] cnt;
   logic [CW-1:0] hold_last;
   logic          last;
   logic          gnt0;
   logic          gnt1;
   logic          hs;
   req_t          req_q;
   req_t          req_sel;
   logic          e_q;
   logic          rs_q;
   logic [7:0]    data_q;
   logic          init_q;
   logic          busy_q;
   logic          nxt_rs;
   logic [7:0]    nxt_data;

   // last = 1 means client 1 won the previous grant
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      unique case (1'b1)
         bus.req0_valid && bus.req1_valid: begin
            gnt0 = last;
            gnt1 = !last;
         end
         bus.req0_valid && !bus.req1_valid: gnt0 = 1'b1;
         !bus.req0_valid && bus.req1_valid: gnt1 = 1'b1;
         default: ;
      endcase
   end

   assign bus.req0_ready = (state == IDLE) && gnt0;
   assign bus.req1_ready = (state == IDLE) && gnt1;
   assign hs = (state == IDLE) && (gnt0 || gnt1);

   assign req_sel = gnt0
      ? {bus.req0_row, bus.req0_col, bus.req0_char}
      : {bus.req1_row, bus.req1_col, bus.req1_char};

   assign hold_last = (state == CLR) ? CLR_LAST : CMD_LAST;

   // Successor of each bus state and the bus values it sets up
   always_comb begin
      nxt_state = IDLE;
      nxt_rs    = rs_q;
      nxt_data  = data_q;
      unique case (state)
         FS: begin
            nxt_state = EM;
            nxt_rs    = 1'b0;
            nxt_data  = 8'h06;
         end
         EM: begin
            nxt_state = DON;
            nxt_rs    = 1'b0;
            nxt_data  = 8'h0C;
         end
         DON: begin
            nxt_state = CLR;
            nxt_rs    = 1'b0;
            nxt_data  = 8'h01;
         end
         ADDR: begin
            nxt_state = CHAR;
            nxt_rs    = 1'b1;
            nxt_data  = req_q.chr;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= PWR_DLY;
         phase  <= SETUP;
         cnt    <= '0;
         last   <= 1'b1;
         req_q  <= '0;
         e_q    <= 1'b0;
         rs_q   <= 1'b0;
         data_q <= 8'h00;
         init_q <= 1'b0;
         busy_q <= 1'b1;
      end else begin
         unique case (state)
            PWR_DLY: begin
               if (cnt == PWR_LAST) begin
                  state  <= FS;
                  phase  <= SETUP;
                  cnt    <= '0;
                  rs_q   <= 1'b0;
                  data_q <= 8'h3C;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            IDLE: begin
               if (hs) begin
                  state  <= ADDR;
                  phase  <= SETUP;
                  cnt    <= '0;
                  last   <= gnt1;
                  req_q  <= req_sel;
                  busy_q <= 1'b1;
                  rs_q   <= 1'b0;
                  data_q <= {1'b1, req_sel.row, 2'b00,
                             req_sel.col};
               end
            end
            default: begin
               unique case (phase)
                  SETUP: begin
                     phase <= STROBE;
                     e_q   <= 1'b1;
                     cnt   <= '0;
                  end
                  STROBE: begin
                     if (cnt == EPW_LAST) begin
                        phase <= HOLD;
                        e_q   <= 1'b0;
                        cnt   <= '0;
                     end else begin
                        cnt <= cnt + 1'b1;
                     end
                  end
                  HOLD: begin
                     if (cnt == hold_last) begin
                        state  <= nxt_state;
                        phase  <= SETUP;
                        cnt    <= '0;
                        rs_q   <= nxt_rs;
                        data_q <= nxt_data;
                        if (nxt_state == IDLE) begin
                           busy_q <= 1'b0;
                           init_q <= 1'b1;
                        end
                     end else begin
                        cnt <= cnt + 1'b1;
                     end
                  end
                  default: phase <= SETUP;
               endcase
            end
         endcase
      end
   end

   assign bus.LCD_E     = e_q;
   assign bus.LCD_RS    = rs_q;
   assign bus.LCD_RW    = 1'b0;
   assign bus.LCD_DATA  = data_q;
   assign bus.init_done = init_q;
   assign bus.busy      = busy_q;
endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Scoreboard bench for lcd_write_arbiter: expected LCD transfers and
// grants are queued at stimulus time and popped as the bus shows them.
module tb_lcd_write_arbiter;
   localparam int PWR_WAIT = 4;
   localparam int E_PW     = 2;
   localparam int CMD_WAIT = 3;
   localparam int CLR_WAIT = 6;
   localparam int INIT_CYC =
      PWR_WAIT + 3 * (1 + E_PW + CMD_WAIT) + (1 + E_PW + CLR_WAIT);
   localparam int WR_CYC = 2 * (1 + E_PW + CMD_WAIT);

   logic clk = 1'b0;
   logic rst = 1'b0;

   lcd_write_arbiter_if bus ();

   lcd_write_arbiter #(
      .PWR_WAIT (PWR_WAIT),
      .E_PW     (E_PW),
      .CMD_WAIT (CMD_WAIT),
      .CLR_WAIT (CLR_WAIT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   logic [8:0] exp_q[$];
   int         gnt_q[$];

   logic       in_pulse = 1'b0;
   int         width = 0;
   logic [8:0] cur;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic push_init();
      exp_q.push_back({1'b0, 8'h3C});
      exp_q.push_back({1'b0, 8'h06});
      exp_q.push_back({1'b0, 8'h0C});
      exp_q.push_back({1'b0, 8'h01});
   endtask

   task automatic push_wr(input int g, input logic row,
                          input logic [3:0] col, input logic [7:0] ch);
      logic [7:0] a;
      a = 8'h80 | (8'(row) << 6) | 8'(col);
      gnt_q.push_back(g);
      exp_q.push_back({1'b0, a});
      exp_q.push_back({1'b1, ch});
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (bus.busy && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      if (bus.busy) check("idle_timeout", 1, 0);
   endtask

   task automatic wait_init(input string tag);
      int n;
      n = 0;
      while (!bus.init_done && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check(tag, n, INIT_CYC);
   endtask

   task automatic wait_hs(input int cnt_hs);
      int n;
      int k;
      n = 0;
      k = 0;
      while (k < cnt_hs && n < 400) begin
         @(negedge clk);
         if ((bus.req0_ready && bus.req0_valid) ||
             (bus.req1_ready && bus.req1_valid)) k++;
         n++;
      end
      if (k < cnt_hs) check("hs_timeout", k, cnt_hs);
   endtask

   // Bus / grant monitor
   always @(negedge clk) begin
      if (!rst) begin
         in_pulse = 1'b0;
         width    = 0;
      end else begin
         if (bus.LCD_E && !in_pulse) begin
            in_pulse = 1'b1;
            width    = 1;
            cur      = {bus.LCD_RS, bus.LCD_DATA};
            if (exp_q.size() == 0) check("unexp_pulse", 1, 0);
            else check("bus_xfer", cur, exp_q.pop_front());
         end else if (bus.LCD_E) begin
            width++;
         end else if (in_pulse) begin
            in_pulse = 1'b0;
            check("e_width", width, E_PW);
            check("bus_stable", {bus.LCD_RS, bus.LCD_DATA}, cur);
         end
         if ((bus.req0_ready || bus.req1_ready) && !bus.init_done)
            check("rdy_early", 1, 0);
         if (bus.req0_ready && bus.req0_valid) begin
            if (gnt_q.size() == 0) check("unexp_grant0", 1, 0);
            else check("grant", 0, gnt_q.pop_front());
         end
         if (bus.req1_ready && bus.req1_valid) begin
            if (gnt_q.size() == 0) check("unexp_grant1", 1, 0);
            else check("grant", 1, gnt_q.pop_front());
         end
      end
   end

   initial begin
      int n;
      bus.req0_valid = 1'b0;
      bus.req0_row   = 1'b0;
      bus.req0_col   = 4'd0;
      bus.req0_char  = 8'h00;
      bus.req1_valid = 1'b0;
      bus.req1_row   = 1'b0;
      bus.req1_col   = 4'd0;
      bus.req1_char  = 8'h00;

      // Reset state and power-up sequence
      push_init();
      repeat (3) @(posedge clk);
      #1;
      check("rst_e", bus.LCD_E, 0);
      check("rst_rs", bus.LCD_RS, 0);
      check("rst_rw", bus.LCD_RW, 0);
      check("rst_data", bus.LCD_DATA, 8'h00);
      check("rst_init", bus.init_done, 0);
      check("rst_busy", bus.busy, 1);
      check("rst_rdy", {bus.req0_ready, bus.req1_ready}, 0);
      rst = 1'b1;
      wait_init("init_cycles");
      check("idle_busy", bus.busy, 0);
      check("init_q", exp_q.size(), 0);

      // Both clients continuously valid: 0,1,0,1
      bus.req0_row  = 1'b0;
      bus.req0_col  = 4'd0;
      bus.req0_char = "X";
      bus.req1_row  = 1'b0;
      bus.req1_col  = 4'd1;
      bus.req1_char = "Y";
      repeat (2) begin
         push_wr(0, 1'b0, 4'd0, "X");
         push_wr(1, 1'b0, 4'd1, "Y");
      end
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b1;
      wait_hs(4);
      @(posedge clk); #1;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      wait_idle();
      check("rr_q", exp_q.size() + gnt_q.size(), 0);

      // Single write, client 0 at (1,5) 'A'
      push_wr(0, 1'b1, 4'd5, "A");
      bus.req0_row   = 1'b1;
      bus.req0_col   = 4'd5;
      bus.req0_char  = "A";
      bus.req0_valid = 1'b1;
      @(negedge clk);
      check("rdy0_single", bus.req0_ready, 1);
      @(posedge clk); #1;
      check("rdy0_pulse", bus.req0_ready, 0);
      bus.req0_valid = 1'b0;
      n = 0;
      while (bus.busy && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("busy_len", n, WR_CYC);
      check("single_q", exp_q.size() + gnt_q.size(), 0);

      // Client 1 arrives while client 0 is in flight
      push_wr(0, 1'b0, 4'd2, "B");
      push_wr(1, 1'b1, 4'd3, "C");
      bus.req0_row   = 1'b0;
      bus.req0_col   = 4'd2;
      bus.req0_char  = "B";
      bus.req0_valid = 1'b1;
      @(posedge clk); #1;
      bus.req0_valid = 1'b0;
      bus.req0_row   = 1'b1;
      bus.req0_col   = 4'd9;
      bus.req0_char  = "Z";
      bus.req1_row   = 1'b1;
      bus.req1_col   = 4'd3;
      bus.req1_char  = "C";
      bus.req1_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (bus.busy && n < 100) begin
         if (bus.req1_ready) n = n + 1000;
         @(negedge clk);
         n++;
      end
      check("rdy1_while_busy", n, WR_CYC);
      check("rdy1_at_idle", bus.req1_ready, 1);
      @(posedge clk); #1;
      bus.req1_valid = 1'b0;
      wait_idle();
      check("late_q", exp_q.size() + gnt_q.size(), 0);

      // Client 0 withdraws before a grant; pointer must not move
      push_wr(1, 1'b0, 4'd15, "D");
      bus.req1_row   = 1'b0;
      bus.req1_col   = 4'd15;
      bus.req1_char  = "D";
      bus.req1_valid = 1'b1;
      @(posedge clk); #1;
      bus.req1_valid = 1'b0;
      bus.req0_row   = 1'b1;
      bus.req0_col   = 4'd0;
      bus.req0_char  = "E";
      bus.req0_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      bus.req0_valid = 1'b0;
      wait_idle();
      repeat (5) @(posedge clk);
      #1;
      check("drop_q", exp_q.size() + gnt_q.size(), 0);
      check("drop_e", bus.LCD_E, 0);
      push_wr(0, 1'b0, 4'd4, "F");
      bus.req0_row   = 1'b0;
      bus.req0_col   = 4'd4;
      bus.req0_char  = "F";
      bus.req1_row   = 1'b0;
      bus.req1_col   = 4'd5;
      bus.req1_char  = "G";
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b1;
      @(posedge clk); #1;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      wait_idle();
      check("ptr_q", exp_q.size() + gnt_q.size(), 0);

      // Reset during the CHAR strobe
      push_wr(0, 1'b1, 4'd1, "H");
      bus.req0_row   = 1'b1;
      bus.req0_col   = 4'd1;
      bus.req0_char  = "H";
      bus.req0_valid = 1'b1;
      @(posedge clk); #1;
      bus.req0_valid = 1'b0;
      n = 0;
      @(negedge clk);
      while (!(bus.LCD_E && bus.LCD_RS) && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("char_strobe_seen", bus.LCD_E && bus.LCD_RS, 1);
      #2;
      rst = 1'b0;
      #1;
      check("arst_e", bus.LCD_E, 0);
      check("arst_rs", bus.LCD_RS, 0);
      check("arst_data", bus.LCD_DATA, 8'h00);
      check("arst_init", bus.init_done, 0);
      check("arst_busy", bus.busy, 1);
      check("arst_q", exp_q.size() + gnt_q.size(), 0);
      push_init();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      wait_init("reinit_cycles");
      repeat (3) @(posedge clk);
      #1;
      check("reinit_q", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/lcd_write_arbiter.md
# lcd_write_arbiter

Sequencer and two-port arbiter for the 16x2 character LCD. It runs the LCD power-up command sequence, then takes single-character write requests from two clients. Example clients: the score/round logic and the status-message logic. Requests are granted round-robin and each becomes an address-set command followed by a data write. It owns LCD_E/LCD_RS/LCD_RW/LCD_DATA; no other block drives the LCD pins.

## Interface
- PWR_WAIT, 70: cycles idle after reset before the first command.
- E_PW, 2: cycles LCD_E is held high per transfer (>=1).
- CMD_WAIT, 40: cycles LCD_E is held low after each non-clear transfer (>=1).
- CLR_WAIT, 200: cycles LCD_E is held low after the clear-display transfer (>=1).
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- req0_valid  in  1  client 0 has a write pending.
- req0_row  in  1  target line (0 = top, 1 = bottom).
- req0_col  in  4  target column 0..15.
- req0_char  in  8  ASCII code to write.
- req0_ready  out  1  client 0 request accepted this cycle.
- req1_valid, req1_row, req1_col, req1_char, req1_ready: same as client 0, for client 1.
- init_done  out  1  power-up sequence finished; stays high until reset.
- busy  out  1  high in every state except IDLE.
- LCD_E  out  1  LCD enable strobe.
- LCD_RS  out  1  0 = command, 1 = data.
- LCD_RW  out  1  always 0 (write only).
- LCD_DATA  out  8  LCD data bus.

## Operation
- States: PWR_DLY, FS, EM, DON, CLR, IDLE, ADDR, CHAR.
- Reset values: state = PWR_DLY; LCD_E = 0, LCD_RS = 0, LCD_RW = 0, LCD_DATA = 0x00; req*_ready = 0; init_done = 0; busy = 1; round-robin pointer = "last grant was 1".
- PWR_DLY: waits PWR_WAIT cycles, then goes to FS.
- Each bus state (FS, EM, DON, CLR, ADDR, CHAR) is one transfer with three phases:
  - setup: 1 cycle, E = 0, RS/DATA valid;
  - strobe: E_PW cycles, E = 1;
  - hold: WAIT cycles, E = 0.
  - WAIT = CLR_WAIT in CLR, CMD_WAIT in every other bus state.
  - RS/DATA are stable for the whole transfer.
- Init transfers, all RS = 0:
  - FS: DATA = 0x3C, then EM;
  - EM: DATA = 0x06, then DON;
  - DON: DATA = 0x0C, then CLR;
  - CLR: DATA = 0x01, then IDLE.
  - init_done is set on entry to IDLE.
- IDLE arbitration:
  - Only one valid: that client is granted.
  - Both valid: the client not granted last time wins.
  - The grant is combinational from the valids and the pointer.
  - req*_ready is high only in IDLE, and only for the granted client.
  - A handshake is valid && ready at a rising edge. On that edge the block latches row/col/char, updates the pointer and goes to ADDR.
- ADDR: RS = 0, DATA = 0x80 | (row << 6) | col. Examples: row 1, col 5 gives 0xC5; row 0, col 0 gives 0x80.
- CHAR: RS = 1, DATA = latched char; then back to IDLE.
- Outside transfers (PWR_DLY, IDLE): E = 0 and RS/DATA hold their last values.
- Clients must hold valid and payload stable until ready. Dropping valid before ready is legal and has no effect. Payload changes after the handshake are ignored.
- Reset mid-operation: all state clears immediately. Any in-flight request is dropped without notification, and the full init sequence reruns.

## Timing
- All outputs are registered except req*_ready, which is a combinational decode of state and grant.
- Transfer length T = 1 + E_PW + WAIT cycles.
- IDLE is reached PWR_WAIT + 3*(1+E_PW+CMD_WAIT) + (1+E_PW+CLR_WAIT) cycles after the first rising edge with rst high.
- Handshake to return to IDLE: 2*(1+E_PW+CMD_WAIT) cycles, after which the next grant can come.
- Maximum throughput is one character per 2*(1+E_PW+CMD_WAIT)+1 cycles, including the IDLE cycle.
- Under continuous requests from both clients, grants alternate 0,1,0,1...; no client waits more than one other transaction.
- Counters are wide enough for max(PWR_WAIT, CLR_WAIT) and never wrap mid-phase.

## Test plan
All scenarios use PWR_WAIT=4, E_PW=2, CMD_WAIT=3, CLR_WAIT=6.
- Power-up, no requests:
  - LCD_DATA sequence 0x3C, 0x06, 0x0C, 0x01, each with one E pulse 2 cycles wide and RS = 0.
  - init_done rises 31 cycles after reset release; ready never asserts before then.
- Single write, client 0 row 1 col 5 'A':
  - ready pulses for 1 cycle.
  - Bus shows 0xC5 with RS = 0, then 0x41 with RS = 1.
  - busy is high for 12 cycles.
- Both clients valid continuously, client 0 'X' at (0,0), client 1 'Y' at (0,1):
  - Grants follow the order 0,1,0,1.
  - Bus sequence 0x80, 0x58, 0x81, 0x59, repeating.
- Client 1 asserts valid during an active client 0 transaction:
  - req1_ready stays low until IDLE, then asserts.
  - Changing client 0 payload after its handshake does not alter LCD_DATA.
- rst pulled low during the strobe phase of CHAR:
  - LCD_E, LCD_RS and LCD_DATA drop to 0 and init_done to 0 without waiting for a clock.
  - After release, the full init sequence repeats.
- Client 0 drops valid before being granted:
  - No ready pulse, the bus stays idle, and the pointer is unchanged.
